// File: rtl/uart_inst_loader.sv
// Boot loader: receives a program over an 8N1 UART link, packs bytes into
// little-endian 32-bit words and writes them to instruction memory while
// holding the core in reset.
module uart_inst_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        word_count
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} ld_state_t;

    rx_state_t         rx_state_q, rx_state_d;
    logic              rx_meta_q, rx_sync_q;
    logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err_q, frame_err_d;

    ld_state_t         state_q, state_d;
    logic [7:0]        word_count_q, word_count_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       acc_q, acc_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              last_word;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Receiver sequencing: mid-bit start check, 8 LSB-first data samples, stop check
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign last_word = (int'(word_idx_q) + 1) == int'(word_count_q);

    // Loader state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            word_count_q <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            acc_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            acc_q        <= acc_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Loader next-state: header decode, finish after the N-th write, abort on framing error
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = HDR;
            HDR: begin
                if (byte_valid_q) begin
                    if (rx_byte_q == 8'd0) state_d = DONE;
                    else if (int'(rx_byte_q) > (1 << ADDR_W)) state_d = ERR;
                    else state_d = DATA;
                end else if (frame_err_q) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (frame_err_q) state_d = ERR;
                else if (mem_we_q && last_word) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Loader datapath: latch header, pack bytes little-endian, issue one write per word
    always_comb begin
        word_count_d = word_count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        acc_d        = acc_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (state_q == HDR && byte_valid_q) begin
            word_count_d = rx_byte_q;
            word_idx_d   = '0;
            byte_idx_d   = '0;
        end
        if (state_q == DATA) begin
            if (byte_valid_q) begin
                case (byte_idx_q)
                    2'd0: acc_d[7:0]   = rx_byte_q;
                    2'd1: acc_d[15:8]  = rx_byte_q;
                    2'd2: acc_d[23:16] = rx_byte_q;
                    default: begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q;
                        mem_wdata_d = {rx_byte_q, acc_q};
                    end
                endcase
                byte_idx_d = byte_idx_q + 2'd1;
            end
            if (mem_we_q && !last_word) word_idx_d = word_idx_q + ADDR_W'(1);
        end
    end

    // Status outputs decoded from the loader state
    always_comb begin
        cpu_hold = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            HDR, DATA: cpu_hold = 1'b1;
            DONE:      done = 1'b1;
            ERR: begin
                err      = 1'b1;
                cpu_hold = 1'b1;
            end
            default: cpu_hold = 1'b0;
        endcase
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;

endmodule
